// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start and the operands; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first two's-complement subtractor: diff = a - b over WIDTH cycles.
// A single full-subtractor cell feeds a registered borrow; operands are captured on the
// accepted start edge, so they may change freely while the operation runs.
// diff/borrow_out only update on the completion edge and otherwise hold.
//
//   state | meaning
//   IDLE  | waiting for start; result outputs hold the last completed value
//   RUN   | one bit per clock, LSB first; busy high
//   DONE  | one-cycle done pulse; start ignored; returns to IDLE
//
// WIDTH must be >= 2.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   sub
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int               CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bo_q,     bo_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             abit, bbit, bin;
  logic             d_bit, bout;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  always_comb begin
    abit     = a_sh_q[0];
    bbit     = b_sh_q[0];
    bin      = borrow_q;
    d_bit    = abit ^ bbit ^ bin;
    bout     = (~abit & bbit) | (~(abit ^ bbit) & bin);
    res_next = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and registered-output decode; busy/done follow the state being entered.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    diff_d   = diff_q;
    bo_d     = bo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sub.start) begin
          a_sh_d   = sub.a;
          b_sh_d   = sub.b;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end
      end

      RUN: begin
        res_d    = res_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = bout;
        count_d  = count_q + ONE;
        if (count_q == LAST) begin
          // Result must include the bit being produced on this edge.
          diff_d  = res_next;
          bo_d    = bout;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      diff_q   <= diff_d;
      bo_q     <= bo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sub.busy       = busy_q;
  assign sub.done       = done_q;
  assign sub.diff       = diff_q;
  assign sub.borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance checked every cycle against a small
// timing model with a result scoreboard, plus a directed check of a 4-bit instance.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (bus8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (bus4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 idle, 1..8 run, 9 done
  int         ph = 0;
  logic [8:0] sbq[$];
  logic [8:0] sb_e;
  logic [7:0] exp_diff = '0;
  logic       exp_bo   = 1'b0;
  logic [7:0] m_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the 8-bit instance each cycle, then predicts the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
      sbq.delete();
      exp_diff = '0;
      exp_bo   = 1'b0;
      chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
      chk("rst_done", {31'd0, bus8.done}, 32'd0);
      chk("rst_diff", {24'd0, bus8.diff}, 32'd0);
      chk("rst_borrow", {31'd0, bus8.borrow_out}, 32'd0);
    end else begin
      chk("busy", {31'd0, bus8.busy}, {31'd0, (ph >= 1 && ph <= 8)});
      chk("done", {31'd0, bus8.done}, {31'd0, (ph == 9)});
      if (ph == 9) begin
        chk("sb_size", sbq.size(), 32'd1);
        if (sbq.size() > 0) begin
          sb_e     = sbq.pop_front();
          exp_diff = sb_e[7:0];
          exp_bo   = sb_e[8];
        end
      end
      chk("diff", {24'd0, bus8.diff}, {24'd0, exp_diff});
      chk("borrow", {31'd0, bus8.borrow_out}, {31'd0, exp_bo});
      if (ph == 0) begin
        if (bus8.start) begin
          m_d = bus8.a - bus8.b;
          sbq.push_back({(bus8.a < bus8.b), m_d});
          ph = 1;
        end
      end else if (ph == 9) begin
        ph = 0;
      end else begin
        ph = ph + 1;
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string tag);
    int n;
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    n = 0;
    while (!bus8.done && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd8);
    chk({tag, "_diff"}, {24'd0, bus8.diff}, {24'd0, ed});
    chk({tag, "_borrow"}, {31'd0, bus8.borrow_out}, {31'd0, eb});
    step();
    step();
  endtask

  initial begin
    int n;
    int ndone;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    repeat (3) step();
    chk("init_diff", {24'd0, bus8.diff}, 32'd0);
    chk("init_busy", {31'd0, bus8.busy}, 32'd0);
    rst_n = 1'b1;
    step();

    op8(8'd100, 8'd37,  8'h3F, 1'b0, "op_100_37");
    op8(8'd37,  8'd100, 8'hC1, 1'b1, "op_37_100");
    op8(8'h00,  8'h01,  8'hFF, 1'b1, "op_00_01");
    op8(8'h55,  8'h55,  8'h00, 1'b0, "op_55_55");

    // start held high; operands only valid when an accept edge is next
    ndone = 0;
    bus8.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ph == 0) begin
        bus8.a = 8'hF0;
        bus8.b = 8'h0F;
      end else begin
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
      step();
      if (bus8.done) begin
        ndone++;
        chk("b2b_diff", {24'd0, bus8.diff}, 32'hE1);
        chk("b2b_borrow", {31'd0, bus8.borrow_out}, 32'd0);
      end
    end
    bus8.start = 1'b0;
    chk("b2b_count", ndone, 32'd4);
    repeat (3) step();

    // reset in the 4th RUN cycle
    bus8.a     = 8'd200;
    bus8.b     = 8'd50;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    repeat (3) step();
    chk("mid_busy", {31'd0, bus8.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
    chk("abort_diff", {24'd0, bus8.diff}, 32'd0);
    chk("abort_borrow", {31'd0, bus8.borrow_out}, 32'd0);
    chk("abort_done", {31'd0, bus8.done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (12) begin
      step();
      chk("abort_no_done", {31'd0, bus8.done}, 32'd0);
    end
    op8(8'd200, 8'd50, 8'd150, 1'b0, "op_200_50");

    // 4-bit instance
    bus4.a     = 4'd3;
    bus4.b     = 4'd5;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    bus4.a     = 4'($urandom);
    bus4.b     = 4'($urandom);
    n = 0;
    while (!bus4.done && n < 20) begin
      chk("w4_busy", {31'd0, bus4.busy}, 32'd1);
      step();
      n++;
    end
    chk("w4_latency", n, 32'd4);
    chk("w4_diff", {28'd0, bus4.diff}, 32'hE);
    chk("w4_borrow", {31'd0, bus4.borrow_out}, 32'd1);
    step();
    chk("w4_done_pulse", {31'd0, bus4.done}, 32'd0);
    chk("w4_hold", {28'd0, bus4.diff}, 32'hE);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
